// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/data/parity/stop
// on device-generated clock edges and checks the device ACK bit.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {StIdle, StInhibit, StStart, StSend, StAck} state_e;

  localparam logic [16:0] InhibitLast = 17'(INHIBIT_CYCLES - 1);
  localparam logic [16:0] TimeoutLast = 17'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  clk_sync_q;
  logic [1:0]  data_sync_q;
  logic [16:0] cnt_q;
  logic [3:0]  bit_idx_q;
  logic [9:0]  frame_q;   // {stop, parity, data[7:0]}
  logic        clk_oe_q;
  logic        data_oe_q;
  logic        done_q;
  logic        err_q;

  logic        clk_fall;
  logic        timed_out;
  logic [16:0] cnt_inc;

  // Synchronise the raw bus lines; idle level of both lines is 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign timed_out = (cnt_q >= TimeoutLast);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 17'd1;

  // Transfer sequencer; all bus drives and status pulses are registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx_valid) begin
            frame_q  <= {1'b1, ~^tx_data, tx_data};
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= StInhibit;
          end
        end
        StInhibit: begin
          // Clock held low alone for the full window, then one cycle with the start bit too.
          if (!data_oe_q) begin
            if (cnt_q == InhibitLast) data_oe_q <= 1'b1;
            else                      cnt_q     <= cnt_q + 17'd1;
          end else begin
            clk_oe_q <= 1'b0;
            state_q  <= StStart;
          end
        end
        StStart: begin
          // The clock line was low until this cycle, so no fall can be missed here.
          bit_idx_q <= '0;
          cnt_q     <= '0;
          state_q   <= StSend;
        end
        StSend: begin
          if (clk_fall) begin
            cnt_q     <= '0;
            data_oe_q <= ~frame_q[bit_idx_q];
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == 4'd9) state_q <= StAck;
          end else if (timed_out) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StAck: begin
          if (clk_fall) begin
            cnt_q   <= '0;
            done_q  <= ~data_sync_q[1];
            err_q   <= data_sync_q[1];
            state_q <= StIdle;
          end else if (timed_out) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign tx_ready    = (state_q == StIdle);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain bus and a behavioural PS/2 device.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned InhibitCycles = 20;
  localparam int unsigned TimeoutCycles = 200;
  localparam int DevHalf = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Wired-AND bus: either side may pull a line low.
  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       ok;     // 1: expect tx_done, 0: expect tx_err
    logic       frame;  // 1: device captured a full frame to compare
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];
  exp_t       e;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pulse_cnt = 0;
  int inh_run = 0;
  bit prev_both = 1'b0;
  int fall4_cyc = 0;
  int err_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen, required within its bound", name);
  endtask

  // Reference frame: data LSB first, odd parity, stop bit 1.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((int'(b) >> i) & 1) == 1;
      ones += (int'(b) >> i) & 1;
    end
    f[8] = (ones % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (resetn && tx_valid && tx_ready) acc_cnt++;
  end

  // Monitor: pops the scoreboard on every completion pulse and tracks the inhibit window.
  always @(negedge clk) begin
    if (resetn) begin
      if (tx_done || tx_err) begin
        pulse_cnt++;
        if (tx_err) err_cyc = cyc;
        check("pulse_exclusive", 32'(tx_done & tx_err), 0);
        check("oe_released_at_end", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("ready_after_end", 32'(tx_ready), 1);
        if (exp_q.size() == 0) begin
          fail("unexpected_pulse");
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", 32'(tx_done), 32'(e.ok));
          if (e.frame) begin
            if (cap_q.size() == 0) fail("frame_capture");
            else check("frame_bits", 32'(cap_q.pop_front()), 32'(ref_frame(e.data)));
          end
        end
      end
      if (prev_both) check("start_state_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 1);
      if (ps2_clk_oe && !ps2_data_oe) inh_run++;
      else if (ps2_clk_oe && ps2_data_oe) begin
        if (!prev_both) check("inhibit_len", inh_run, InhibitCycles);
      end else inh_run = 0;
      prev_both = ps2_clk_oe && ps2_data_oe;
    end
  end

  // Device model. mode 0: ACK, 1: no ACK, 2: stop clocking after fall 4,
  // 3: assert reset shortly after fall 6.
  task automatic device_frame(input int mode);
    logic [9:0] cap;
    int n;
    bit seen;
    cap = '0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (ps2_clk && !ps2_data) seen = 1'b1;
    end
    if (!seen) begin
      fail("device_start_bit");
      return;
    end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (mode == 2 && k == 4) fall4_cyc = cyc;
      if (mode == 3 && k == 6) begin
        repeat (4) @(negedge clk);
        check("data_oe_before_reset", 32'(ps2_data_oe), 1);
        resetn = 1'b0;
        #1;
        check("reset_async_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (DevHalf - 7) @(negedge clk);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (DevHalf) @(negedge clk);
      dev_clk_low = 1'b0;
      cap[k-1] = ps2_data;
      if (mode == 2 && k == 4) return;
      repeat (DevHalf) @(negedge clk);
    end
    cap_q.push_back(cap);
    repeat (5) @(negedge clk);
    if (mode == 0) dev_data_low = 1'b1;
    repeat (DevHalf - 5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (DevHalf) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) fail("ready_wait");
  endtask

  task automatic issue(input logic [7:0] b, input int mode);
    wait_ready();
    if (mode != 3) exp_q.push_back(exp_t'({b, mode == 0, mode <= 1}));
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("completion_wait");
      exp_q.delete();
      cap_q.delete();
    end
  endtask

  task automatic transfer(input logic [7:0] b, input int mode);
    fork
      issue(b, mode);
      device_frame(mode);
    join
    drain();
  endtask

  // tx_valid stays high with scrambled data through the first transfer.
  task automatic hold_test(input logic [7:0] a, input logic [7:0] b2);
    int acc0;
    int n;
    fork
      begin
        device_frame(0);
        device_frame(0);
      end
      begin
        wait_ready();
        acc0 = acc_cnt;
        exp_q.push_back(exp_t'({a, 1'b1, 1'b1}));
        tx_data  = a;
        tx_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!tx_ready && n < 2000) begin
          tx_data = 8'($urandom);
          @(negedge clk);
          n++;
        end
        check("single_accept_while_busy", acc_cnt - acc0, 1);
        exp_q.push_back(exp_t'({b2, 1'b1, 1'b1}));
        tx_data = b2;
        @(negedge clk);
        tx_valid = 1'b0;
        check("next_accept_after_done", acc_cnt - acc0, 2);
      end
    join
    drain();
  endtask

  initial begin
    int pc;
    int d;
    logic [7:0] b;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(tx_ready), 1);

    transfer(8'hED, 0);
    transfer(8'h00, 0);
    transfer(8'hFF, 0);
    transfer(8'h5A, 1);
    transfer(8'h3C, 2);
    d = err_cyc - fall4_cyc;
    check("timeout_delay", 32'(d >= 201 && d <= 205), 1);

    pc = pulse_cnt;
    transfer(8'h00, 3);
    repeat (300) @(negedge clk);
    check("no_pulse_on_reset", pulse_cnt - pc, 0);
    check("ready_after_midreset", 32'(tx_ready), 1);
    transfer(8'hF4, 0);

    hold_test(8'hA7, 8'h19);

    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      transfer(b, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
